y86_decode_stage: RTL and testbench

Pipelined, parametrised successor to the combinational decode logic of the Y86 processor. It owns the architectural register file. It derives srcA/srcB/dstE/dstM from icode/rA/rB and resolves operands through a forwarding network from the execute, memory and writeback stages. It detects load-use hazards and delivers a registered decode/execute pipeline register under a valid/ready handshake.

---
 rtl/y86_pkg.sv | 54 +++++
 rtl/y86_decode_stage_if.sv | 55 +++++
 rtl/y86_regfile.sv | 37 +++
 rtl/y86_decode_stage.sv | 135 +++++++++++++
 tb/tb_y86_decode_stage.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 decode definitions: instruction codes, special register ids,
// and the source/destination register selection functions.
package y86_pkg;

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_RRMOVQ = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_e;

    localparam logic [3:0] REG_NONE = 4'hF;
    localparam logic [3:0] REG_RSP  = 4'h4;

    function automatic logic [3:0] f_src_a(input logic [3:0] icode, input logic [3:0] ra);
        case (icode)
            I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: return ra;
            I_RET, I_POPQ:                      return REG_RSP;
            default:                            return REG_NONE;
        endcase
    endfunction

    function automatic logic [3:0] f_src_b(input logic [3:0] icode, input logic [3:0] rb);
        case (icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ:           return rb;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:      return REG_RSP;
            default:                             return REG_NONE;
        endcase
    endfunction

    function automatic logic [3:0] f_dst_e(input logic [3:0] icode, input logic [3:0] rb);
        case (icode)
            I_RRMOVQ, I_IRMOVQ, I_OPQ:           return rb;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:      return REG_RSP;
            default:                             return REG_NONE;
        endcase
    endfunction

    function automatic logic [3:0] f_dst_m(input logic [3:0] icode, input logic [3:0] ra);
        case (icode)
            I_MRMOVQ, I_POPQ: return ra;
            default:          return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/y86_decode_stage_if.sv
// Fetch->decode->execute handshake bus plus the forwarding/writeback
// buses feeding the decode stage. master = surrounding pipeline,
// slave = decode stage.
interface y86_decode_stage_if #(parameter int unsigned W = 64);
    logic           in_valid;
    logic           in_ready;
    logic [3:0]     in_icode;
    logic [3:0]     in_ifun;
    logic [3:0]     in_rA;
    logic [3:0]     in_rB;
    logic [W-1:0]   in_valC;
    logic [W-1:0]   in_valP;
    logic           flush;
    logic [3:0]     e_dstE;
    logic [W-1:0]   e_valE;
    logic           e_load;
    logic [3:0]     e_dstM;
    logic [3:0]     m_dstE;
    logic [3:0]     m_dstM;
    logic [W-1:0]   m_valE;
    logic [W-1:0]   m_valM;
    logic [3:0]     w_dstE;
    logic [3:0]     w_dstM;
    logic [W-1:0]   w_valE;
    logic [W-1:0]   w_valM;
    logic           out_valid;
    logic           out_ready;
    logic [3:0]     out_icode;
    logic [3:0]     out_ifun;
    logic [W-1:0]   out_valA;
    logic [W-1:0]   out_valB;
    logic [W-1:0]   out_valC;
    logic [W-1:0]   out_valP;
    logic [3:0]     out_srcA;
    logic [3:0]     out_srcB;
    logic [3:0]     out_dstE;
    logic [3:0]     out_dstM;
    logic           out_inv;

    modport master (
        output in_valid, in_icode, in_ifun, in_rA, in_rB, in_valC, in_valP, flush,
               e_dstE, e_valE, e_load, e_dstM, m_dstE, m_dstM, m_valE, m_valM,
               w_dstE, w_dstM, w_valE, w_valM, out_ready,
        input  in_ready, out_valid, out_icode, out_ifun, out_valA, out_valB,
               out_valC, out_valP, out_srcA, out_srcB, out_dstE, out_dstM, out_inv
    );

    modport slave (
        input  in_valid, in_icode, in_ifun, in_rA, in_rB, in_valC, in_valP, flush,
               e_dstE, e_valE, e_load, e_dstM, m_dstE, m_dstM, m_valE, m_valM,
               w_dstE, w_dstM, w_valE, w_valM, out_ready,
        output in_ready, out_valid, out_icode, out_ifun, out_valA, out_valB,
               out_valC, out_valP, out_srcA, out_srcB, out_dstE, out_dstM, out_inv
    );
endinterface

// File: rtl/y86_regfile.sv
// Architectural register file: NREG x W, two async read ports, two write
// ports (dstM wins when both target the same id), synchronous clear.
module y86_regfile #(
    parameter int unsigned W    = 64,
    parameter int unsigned NREG = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   i_src_a,
    input  logic [3:0]   i_src_b,
    output logic [W-1:0] o_val_a,
    output logic [W-1:0] o_val_b,
    input  logic [3:0]   i_dst_e,
    input  logic [W-1:0] i_val_e,
    input  logic [3:0]   i_dst_m,
    input  logic [W-1:0] i_val_m
);
    logic [W-1:0] r_regs [NREG];

    // Clear on reset, otherwise write each register whose id is targeted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (i_dst_m == 4'(i))      r_regs[i] <= i_val_m;
                else if (i_dst_e == 4'(i)) r_regs[i] <= i_val_e;
            end
        end
    end

    // Unimplemented ids (including "none") read as zero.
    always_comb begin
        o_val_a = (32'(i_src_a) < NREG) ? r_regs[i_src_a] : '0;
        o_val_b = (32'(i_src_b) < NREG) ? r_regs[i_src_b] : '0;
    end
endmodule

// File: rtl/y86_decode_stage.sv
// Y86 decode stage: register selection, operand forwarding, hazard stall
// and a registered decode/execute output under valid/ready.
// Optional feature macro: FWD_EN (execute/memory forwarding; when undefined
// any pending execute/memory destination match stalls instead).
module y86_decode_stage
    import y86_pkg::*;
#(
    parameter int unsigned W    = 64,
    parameter int unsigned NREG = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    y86_decode_stage_if.slave bus
);
    logic [3:0]   w_src_a, w_src_b, w_dst_e, w_dst_m;
    logic         w_inv, w_adv, w_hazard;
    logic [W-1:0] w_rf_a, w_rf_b, w_val_a, w_val_b;

    logic         r_valid, r_inv;
    logic [3:0]   r_icode, r_ifun, r_src_a, r_src_b, r_dst_e, r_dst_m;
    logic [W-1:0] r_val_a, r_val_b, r_val_c, r_val_p;

    y86_regfile #(.W(W), .NREG(NREG)) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_src_a (w_src_a),
        .i_src_b (w_src_b),
        .o_val_a (w_rf_a),
        .o_val_b (w_rf_b),
        .i_dst_e (bus.w_dstE),
        .i_val_e (bus.w_valE),
        .i_dst_m (bus.w_dstM),
        .i_val_m (bus.w_valM)
    );

    // Newest producer wins; writeback ports double as the write-before-read bypass.
    function automatic logic [W-1:0] f_resolve(input logic [3:0] src, input logic [W-1:0] rf_val);
        logic [W-1:0] v;
        v = rf_val;
        if (src == REG_NONE)         v = '0;
`ifdef FWD_EN
        else if (src == bus.e_dstE)  v = bus.e_valE;
        else if (src == bus.m_dstM)  v = bus.m_valM;
        else if (src == bus.m_dstE)  v = bus.m_valE;
`endif
        else if (src == bus.w_dstM)  v = bus.w_valM;
        else if (src == bus.w_dstE)  v = bus.w_valE;
        return v;
    endfunction

`ifndef FWD_EN
    // Without e/m forwarding, any in-flight destination matching a source must wait.
    function automatic logic f_conflict(input logic [3:0] src);
        return (src != REG_NONE) &&
               (src == bus.e_dstE || src == bus.e_dstM ||
                src == bus.m_dstE || src == bus.m_dstM);
    endfunction

    logic w_unused_nofwd;
    assign w_unused_nofwd = ^{bus.e_load, bus.e_valE, bus.m_valE, bus.m_valM};
`endif

    // Decode register ids and resolve operands for the incoming instruction.
    always_comb begin
        w_inv   = (bus.in_icode > 4'hB);
        w_src_a = f_src_a(bus.in_icode, bus.in_rA);
        w_src_b = f_src_b(bus.in_icode, bus.in_rB);
        w_dst_e = f_dst_e(bus.in_icode, bus.in_rB);
        w_dst_m = f_dst_m(bus.in_icode, bus.in_rA);
        w_val_a = f_resolve(w_src_a, w_rf_a);
        w_val_b = f_resolve(w_src_b, w_rf_b);
    end

    // Hazard detection and handshake readiness.
    always_comb begin
`ifdef FWD_EN
        w_hazard = bus.e_load && (bus.e_dstM != REG_NONE) &&
                   (bus.e_dstM == w_src_a || bus.e_dstM == w_src_b);
`else
        w_hazard = f_conflict(w_src_a) || f_conflict(w_src_b);
`endif
        w_adv        = !r_valid || bus.out_ready;
        bus.in_ready = bus.flush || (w_adv && !w_hazard);
    end

    // Decode/execute pipeline register; flush clears valid even under back-pressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_inv   <= 1'b0;
            r_icode <= '0;
            r_ifun  <= '0;
            r_val_a <= '0;
            r_val_b <= '0;
            r_val_c <= '0;
            r_val_p <= '0;
            r_src_a <= REG_NONE;
            r_src_b <= REG_NONE;
            r_dst_e <= REG_NONE;
            r_dst_m <= REG_NONE;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (w_adv) begin
            if (w_hazard || !bus.in_valid) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= 1'b1;
                r_inv   <= w_inv;
                r_icode <= bus.in_icode;
                r_ifun  <= bus.in_ifun;
                r_val_a <= w_val_a;
                r_val_b <= w_val_b;
                r_val_c <= bus.in_valC;
                r_val_p <= bus.in_valP;
                r_src_a <= w_src_a;
                r_src_b <= w_src_b;
                r_dst_e <= w_dst_e;
                r_dst_m <= w_dst_m;
            end
        end
    end

    assign bus.out_valid = r_valid;
    assign bus.out_inv   = r_inv;
    assign bus.out_icode = r_icode;
    assign bus.out_ifun  = r_ifun;
    assign bus.out_valA  = r_val_a;
    assign bus.out_valB  = r_val_b;
    assign bus.out_valC  = r_val_c;
    assign bus.out_valP  = r_val_p;
    assign bus.out_srcA  = r_src_a;
    assign bus.out_srcB  = r_src_b;
    assign bus.out_dstE  = r_dst_e;
    assign bus.out_dstM  = r_dst_m;
endmodule

// File: tb/tb_y86_decode_stage.sv
// Directed self-checking bench for y86_decode_stage.
module tb_y86_decode_stage;
    localparam int unsigned W = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    y86_decode_stage_if #(.W(W)) bus();

    y86_decode_stage #(.W(W), .NREG(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.in_valid  = 1'b0;
        bus.in_icode  = 4'h1;
        bus.in_ifun   = 4'h0;
        bus.in_rA     = 4'hF;
        bus.in_rB     = 4'hF;
        bus.in_valC   = '0;
        bus.in_valP   = '0;
        bus.flush     = 1'b0;
        bus.e_dstE    = 4'hF;
        bus.e_valE    = '0;
        bus.e_load    = 1'b0;
        bus.e_dstM    = 4'hF;
        bus.m_dstE    = 4'hF;
        bus.m_dstM    = 4'hF;
        bus.m_valE    = '0;
        bus.m_valM    = '0;
        bus.w_dstE    = 4'hF;
        bus.w_dstM    = 4'hF;
        bus.w_valE    = '0;
        bus.w_valM    = '0;
        bus.out_ready = 1'b1;
    endtask

    task automatic set_instr(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                             input logic [3:0] rb, input logic [63:0] c, input logic [63:0] p);
        bus.in_valid = 1'b1;
        bus.in_icode = ic;
        bus.in_ifun  = fn;
        bus.in_rA    = ra;
        bus.in_rB    = rb;
        bus.in_valC  = c;
        bus.in_valP  = p;
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 1'b0;
        set_instr(4'h2, 4'h0, 4'h2, 4'h3, 64'h0, 64'h0);
        bus.w_dstE = 4'h2;
        bus.w_valE = 64'h99;
        tick();
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %h exp 0", bus.out_valid); end
        checks++; if (bus.out_valA !== 64'h0) begin errors++; $display("FAIL rst_valA got %h exp 0", bus.out_valA); end
        checks++; if (bus.out_valC !== 64'h0) begin errors++; $display("FAIL rst_valC got %h exp 0", bus.out_valC); end
        checks++; if (bus.out_srcA !== 4'hF) begin errors++; $display("FAIL rst_srcA got %h exp f", bus.out_srcA); end
        checks++; if (bus.out_dstM !== 4'hF) begin errors++; $display("FAIL rst_dstM got %h exp f", bus.out_dstM); end
        checks++; if (bus.out_inv !== 1'b0) begin errors++; $display("FAIL rst_inv got %h exp 0", bus.out_inv); end
        rst_n = 1'b1;
        bus.w_dstE = 4'hF;
        tick();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %h exp 1", bus.out_valid); end
        checks++; if (bus.out_valA !== 64'h0) begin errors++; $display("FAIL first_valA got %h exp 0", bus.out_valA); end
        checks++; if (bus.out_srcA !== 4'h2) begin errors++; $display("FAIL first_srcA got %h exp 2", bus.out_srcA); end
        checks++; if (bus.out_srcB !== 4'hF) begin errors++; $display("FAIL first_srcB got %h exp f", bus.out_srcB); end
        checks++; if (bus.out_dstE !== 4'h3) begin errors++; $display("FAIL first_dstE got %h exp 3", bus.out_dstE); end
    endtask

    task automatic test_wb_bypass();
        set_instr(4'h6, 4'h0, 4'h2, 4'h3, 64'h0, 64'h0);
        bus.w_dstE = 4'h2;
        bus.w_valE = 64'h55;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL wb_ready got %h exp 1", bus.in_ready); end
        tick();
        checks++; if (bus.out_valA !== 64'h55) begin errors++; $display("FAIL wb_valA got %h exp 55", bus.out_valA); end
        checks++; if (bus.out_valB !== 64'h0) begin errors++; $display("FAIL wb_valB got %h exp 0", bus.out_valB); end
        checks++; if (bus.out_dstE !== 4'h3) begin errors++; $display("FAIL wb_dstE got %h exp 3", bus.out_dstE); end
        checks++; if (bus.out_icode !== 4'h6) begin errors++; $display("FAIL wb_icode got %h exp 6", bus.out_icode); end
        // both write ports on reg 5: valM must win, both in bypass and in the file
        set_instr(4'h4, 4'h0, 4'h5, 4'h2, 64'h8, 64'h10);
        bus.w_dstE = 4'h5;
        bus.w_valE = 64'h11;
        bus.w_dstM = 4'h5;
        bus.w_valM = 64'h22;
        tick();
        checks++; if (bus.out_valA !== 64'h22) begin errors++; $display("FAIL dual_valA got %h exp 22", bus.out_valA); end
        checks++; if (bus.out_valB !== 64'h55) begin errors++; $display("FAIL rf_reg2 got %h exp 55", bus.out_valB); end
        checks++; if (bus.out_dstE !== 4'hF) begin errors++; $display("FAIL rmmov_dstE got %h exp f", bus.out_dstE); end
        set_instr(4'h2, 4'h0, 4'h5, 4'h7, 64'h0, 64'h0);
        bus.w_dstE = 4'hF;
        bus.w_dstM = 4'hF;
        tick();
        checks++; if (bus.out_valA !== 64'h22) begin errors++; $display("FAIL rf_reg5 got %h exp 22", bus.out_valA); end
    endtask

`ifdef FWD_EN
    task automatic test_priority();
        set_instr(4'hA, 4'h0, 4'h3, 4'hF, 64'h0, 64'h0);
        bus.e_dstE = 4'h3; bus.e_valE = 64'h10;
        bus.m_dstE = 4'h3; bus.m_valE = 64'h20;
        bus.w_dstE = 4'h3; bus.w_valE = 64'h30;
        tick();
        checks++; if (bus.out_valA !== 64'h10) begin errors++; $display("FAIL prio_e got %h exp 10", bus.out_valA); end
        checks++; if (bus.out_srcB !== 4'h4) begin errors++; $display("FAIL push_srcB got %h exp 4", bus.out_srcB); end
        checks++; if (bus.out_dstE !== 4'h4) begin errors++; $display("FAIL push_dstE got %h exp 4", bus.out_dstE); end
        checks++; if (bus.out_valB !== 64'h0) begin errors++; $display("FAIL push_valB got %h exp 0", bus.out_valB); end
        bus.e_dstE = 4'hF;
        bus.m_dstM = 4'h3; bus.m_valM = 64'h40;
        tick();
        checks++; if (bus.out_valA !== 64'h40) begin errors++; $display("FAIL prio_mM got %h exp 40", bus.out_valA); end
        bus.m_dstM = 4'hF;
        tick();
        checks++; if (bus.out_valA !== 64'h20) begin errors++; $display("FAIL prio_mE got %h exp 20", bus.out_valA); end
        bus.m_dstE = 4'hF;
        tick();
        checks++; if (bus.out_valA !== 64'h30) begin errors++; $display("FAIL prio_w got %h exp 30", bus.out_valA); end
        bus.w_dstE = 4'hF;
    endtask
`else
    task automatic test_nofwd_stall();
        set_instr(4'h6, 4'h0, 4'h3, 4'h6, 64'h0, 64'h0);
        bus.m_dstE = 4'h3;
        bus.m_valE = 64'h20;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL nofwd_ready%0d got %h exp 0", i, bus.in_ready); end
            tick();
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL nofwd_valid%0d got %h exp 0", i, bus.out_valid); end
        end
        bus.m_dstE = 4'hF;
        bus.w_dstE = 4'h3;
        bus.w_valE = 64'h77;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL nofwd_release got %h exp 1", bus.in_ready); end
        tick();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL nofwd_issue got %h exp 1", bus.out_valid); end
        checks++; if (bus.out_valA !== 64'h77) begin errors++; $display("FAIL nofwd_valA got %h exp 77", bus.out_valA); end
        bus.w_dstE = 4'hF;
    endtask
`endif

    task automatic test_load_use();
        set_instr(4'h6, 4'h1, 4'h1, 4'h5, 64'h0, 64'h0);
        bus.e_load = 1'b1;
        bus.e_dstM = 4'h1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL lu_ready%0d got %h exp 0", i, bus.in_ready); end
            tick();
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL lu_valid%0d got %h exp 0", i, bus.out_valid); end
        end
        bus.e_load = 1'b0;
        bus.e_dstM = 4'hF;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL lu_release got %h exp 1", bus.in_ready); end
        tick();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL lu_issue got %h exp 1", bus.out_valid); end
        checks++; if (bus.out_ifun !== 4'h1) begin errors++; $display("FAIL lu_ifun got %h exp 1", bus.out_ifun); end
        checks++; if (bus.out_srcA !== 4'h1) begin errors++; $display("FAIL lu_srcA got %h exp 1", bus.out_srcA); end
        checks++; if (bus.out_valB !== 64'h22) begin errors++; $display("FAIL lu_valB got %h exp 22", bus.out_valB); end
    endtask

    task automatic test_backpressure_flush();
        set_instr(4'h3, 4'h0, 4'hF, 4'h6, 64'hABC, 64'h100);
        tick();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL irmov_valid got %h exp 1", bus.out_valid); end
        checks++; if (bus.out_valC !== 64'hABC) begin errors++; $display("FAIL irmov_valC got %h exp abc", bus.out_valC); end
        checks++; if (bus.out_valP !== 64'h100) begin errors++; $display("FAIL irmov_valP got %h exp 100", bus.out_valP); end
        checks++; if (bus.out_dstE !== 4'h6) begin errors++; $display("FAIL irmov_dstE got %h exp 6", bus.out_dstE); end
        checks++; if (bus.out_valA !== 64'h0) begin errors++; $display("FAIL irmov_valA got %h exp 0", bus.out_valA); end
        bus.out_ready = 1'b0;
        set_instr(4'h1, 4'h0, 4'hF, 4'hF, 64'h1, 64'h2);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready%0d got %h exp 0", i, bus.in_ready); end
            tick();
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid%0d got %h exp 1", i, bus.out_valid); end
            checks++; if (bus.out_valC !== 64'hABC) begin errors++; $display("FAIL bp_valC%0d got %h exp abc", i, bus.out_valC); end
        end
        bus.flush = 1'b1;
        set_instr(4'h0, 4'h0, 4'hF, 4'hF, 64'hDEAD, 64'h3);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %h exp 1", bus.in_ready); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %h exp 0", bus.out_valid); end
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_discard got %h exp 0", bus.out_valid); end
    endtask

    task automatic test_invalid();
        set_instr(4'hC, 4'h0, 4'h2, 4'h5, 64'h0, 64'h0);
        tick();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL inv_valid got %h exp 1", bus.out_valid); end
        checks++; if (bus.out_inv !== 1'b1) begin errors++; $display("FAIL inv_flag got %h exp 1", bus.out_inv); end
        checks++; if ({bus.out_srcA, bus.out_srcB, bus.out_dstE, bus.out_dstM} !== 16'hFFFF) begin
            errors++; $display("FAIL inv_ids got %h exp ffff", {bus.out_srcA, bus.out_srcB, bus.out_dstE, bus.out_dstM}); end
        checks++; if ({bus.out_valA, bus.out_valB} !== 128'h0) begin
            errors++; $display("FAIL inv_vals got %h_%h exp 0_0", bus.out_valA, bus.out_valB); end
        set_instr(4'hB, 4'h0, 4'h7, 4'hF, 64'h0, 64'h0);
        tick();
        checks++; if (bus.out_inv !== 1'b0) begin errors++; $display("FAIL pop_inv got %h exp 0", bus.out_inv); end
        checks++; if ({bus.out_srcA, bus.out_srcB, bus.out_dstE, bus.out_dstM} !== 16'h4447) begin
            errors++; $display("FAIL pop_ids got %h exp 4447", {bus.out_srcA, bus.out_srcB, bus.out_dstE, bus.out_dstM}); end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wb_bypass();
`ifdef FWD_EN
        test_priority();
`else
        test_nofwd_stall();
`endif
        test_load_use();
        test_backpressure_flush();
        test_invalid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
